// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU-to-SRAM bridge: controller states, request kinds,
// wait-counter width and the latched request payload.
package cpu_mem_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_INST  = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  // A write request wins over a read request raised in the same cycle.
  function automatic kind_e decode_kind(input logic mem_read, input logic mem_write);
    if (mem_write) return KIND_STORE;
    else if (mem_read) return KIND_LOAD;
    else return KIND_INST;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state down-counter: loaded on request acceptance, decremented once per
// WAIT cycle, done flags the last wait cycle.
module mem_wait_timer
  import cpu_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_val,
  input  logic                  dec,
  output logic                  done
);

  logic [WAIT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WAIT_CNT_W'(1);
    end
  end

  assign done = (cnt_q == WAIT_CNT_W'(1));

endmodule

// File: rtl/cpu_mem_bridge.sv
// Arbitrates CPU instruction-fetch and data requests onto a single-port SRAM
// with optional wait states and a held response channel per requester.
module cpu_mem_bridge
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           PC,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ack,
  output logic [31:0]           Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ack,
  input  logic [31:0]           Address,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [31:0]           Write_data,
  input  logic [3:0]            Write_strb,
  output logic                  Mem_Req_Ack,
  output logic [31:0]           Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ack,
  output logic                  mem_en,
  output logic [3:0]            mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  state_e                state_q, state_d;
  req_t                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           inst_q, rdat_q;
  logic                  resp_first_q;
  logic                  data_req, accept;
  logic                  tmr_load, tmr_dec, tmr_done;
  logic                  unused_ok;

  assign data_req  = MemRead | MemWrite;
  assign unused_ok = ^{PC[31:ADDR_WIDTH+2], PC[1:0], Address[31:ADDR_WIDTH+2], Address[1:0]};

  mem_wait_timer u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and strobes; everything is forced idle during reset so an
  // in-flight access never reaches the SRAM in the reset cycle.
  always_comb begin
    state_d         = state_q;
    Mem_Req_Ack     = 1'b0;
    Inst_Req_Ack    = 1'b0;
    accept          = 1'b0;
    tmr_load        = 1'b0;
    tmr_dec         = 1'b0;
    mem_en          = 1'b0;
    mem_wen         = 4'b0000;
    Inst_Valid      = 1'b0;
    Read_data_Valid = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          Mem_Req_Ack  = data_req;
          Inst_Req_Ack = Inst_Req_Valid & ~data_req;
          accept       = data_req | Inst_Req_Valid;
          if (accept) begin
            tmr_load = 1'b1;
            state_d  = (WAIT_CYCLES != 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          tmr_dec = 1'b1;
          if (tmr_done) state_d = ST_ACCESS;
        end
        ST_ACCESS: begin
          mem_en = 1'b1;
          if (req_q.kind == KIND_STORE) begin
            mem_wen = req_q.strb;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          Inst_Valid      = (req_q.kind == KIND_INST);
          Read_data_Valid = (req_q.kind == KIND_LOAD);
          if ((Inst_Valid && Inst_Ack) || (Read_data_Valid && Read_data_Ack)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Request latch and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q        <= '{kind: KIND_INST, wdata: 32'h0, strb: 4'h0};
      addr_q       <= '0;
      inst_q       <= 32'h0;
      rdat_q       <= 32'h0;
      resp_first_q <= 1'b0;
    end else begin
      resp_first_q <= (state_q == ST_ACCESS) && (req_q.kind != KIND_STORE);
      if (accept) begin
        req_q  <= '{kind: decode_kind(MemRead, MemWrite), wdata: Write_data, strb: Write_strb};
        addr_q <= data_req ? Address[ADDR_WIDTH+1:2] : PC[ADDR_WIDTH+1:2];
      end
      if (resp_first_q) begin
        if (req_q.kind == KIND_INST) inst_q <= mem_rdata;
        else                         rdat_q <= mem_rdata;
      end
    end
  end

  // SRAM data only arrives in the first RESP cycle, so that cycle forwards it
  // directly; the captured copy covers the rest of RESP (SRAM idle, so equal).
  assign Instruction = (resp_first_q && !rst && req_q.kind == KIND_INST) ? mem_rdata : inst_q;
  assign Read_data   = (resp_first_q && !rst && req_q.kind == KIND_LOAD) ? mem_rdata : rdat_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = req_q.wdata;

endmodule
